hash_core_driver: RTL
=====================

// Module: hash_core_driver
// PURPOSE
//  Host-side initiator for the single-block hash_core. Takes one message (<= one rate block) from an
//  upstream valid/ready stream and applies SHA-3 padding (0x06 .. 0x80). Pushes the 50-word state image
//  into hash_core over en/wen/din, waits for done, then drains OUT_WORDS digest words via dout_req
//  onto a downstream valid/ready stream. Sits between the bus/DMA front-end and hash_core.
// PARAMETERS
//  RATE_WORDS  34  rate in 32-bit words (34 = SHA3-256, 42 = SHAKE128); must be < 50
//  OUT_WORDS   8   digest words read back; 1..RATE_WORDS
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   begin one hash; sampled only in IDLE
//  msg_bytes    in   8   message length in bytes, sampled with start; legal 0..RATE_WORDS*4-1
//  msg_valid    in   1   upstream word valid
//  msg_data     in   32  message word, little-endian (byte k = bits [8k+7:8k])
//  msg_ready    out  1   upstream word accepted when msg_valid & msg_ready
//  dig_valid    out  1   digest word valid
//  dig_data     out  32  digest word, little-endian, word 0 first
//  dig_last     out  1   marks digest word OUT_WORDS-1
//  dig_ready    in   1   downstream accept
//  busy         out  1   high in every state except IDLE
//  err          out  1   one-cycle pulse: start with illegal msg_bytes (request dropped, stays IDLE)
//  hc_en        out  1   to hash_core en
//  hc_wen       out  1   to hash_core wen
//  hc_din       out  32  to hash_core din
//  hc_dout_req  out  1   to hash_core dout_req
//  hc_dout      in   32  from hash_core dout
//  hc_valid     in   1   from hash_core valid (monitor only)
//  hc_done      in   1   from hash_core done
// BEHAVIOUR
//  Reset: FSM=IDLE; all counters 0.
//  Reset outputs: msg_ready, dig_valid, dig_last, busy, err, hc_en, hc_wen, hc_dout_req = 0; hc_din = 0.
//  Reset mid-operation aborts silently. hash_core is NOT reset by this block; the next start's hc_en
//  re-inits it.
//  FSM: IDLE -> EN -> GAP -> ABSORB -> WAIT -> SQUEEZE -> IDLE.
//   IDLE: start & msg_bytes<RATE_WORDS*4 -> latch L=msg_bytes, go EN. Illegal length -> err pulse, stay.
//   EN: hc_en=1 for exactly one cycle; word index w=0.
//   GAP: one idle cycle so hash_core's init completes before the first wen.
//   ABSORB: for w=0..49, one registered hc_wen/hc_din per word.
//    - w < ceil(L/4): word needs upstream data; msg_ready=1 only when the word can issue.
//      The word issues on msg_valid&msg_ready. No valid means no wen that cycle; gaps are legal.
//    - Other w: driver-generated, issues every cycle.
//    - Word content: message bytes < L kept; bytes >= L zeroed.
//    - Byte L ^= 0x06; byte RATE_WORDS*4-1 ^= 0x80. L = RATE*4-1 gives single byte 0x86.
//    - w >= RATE_WORDS: zero (capacity).
//    - After w=49 issues, go WAIT. Extra upstream words are never accepted (msg_ready=0).
//   WAIT: hold until hc_done=1, then SQUEEZE with out index o=0.
//   SQUEEZE: dig_valid=1, dig_data=hc_dout (combinational pass-through), dig_last=(o==OUT_WORDS-1).
//    - hc_dout_req = dig_valid & dig_ready, so hash_core shifts only on acceptance.
//    - On accept, o++. After accepting o=OUT_WORDS-1, go IDLE.
//  start while busy: ignored, no err. hc_valid is not used for control.
//  Throughput: with no stalls, en->last wen = 52 cycles; permutation is 48 core cycles.
// STRUCTURE
//  sha3_pkg: STATE_WORDS=50, PAD_DS=8'h06, PAD_END=8'h80, FSM state encoding,
//   function pad_word(data, w, L, RATE_WORDS) returning the masked/padded word.
//  Single module; no sub-module. Padding is pure combinational logic in the package function.
// TESTING
//  1 Empty msg, RATE=34, OUT=8: start L=0, no upstream words.
//    -> din w0=0x00000006, w33=0x80000000, rest 0. dig w0=0xf8c6ffa7 (SHA3-256 a7ffc6f8..).
//  2 "abc": L=3, one word 0x00636261 -> din w0=0x06636261.
//    -> dig w0=0xa75d983a (3a985da7..); dig_last on 8th word only.
//  3 L=135: 34 words; last word byte3 = 0x86; no separate 0x80 word.
//    -> compare full digest to software model.
//  4 Backpressure: random msg_valid and dig_ready gaps.
//    -> wen count exactly 50; digest unchanged vs test 2; no dout_req without dig_ready.
//  5 start with L=136 -> err pulses one cycle, busy stays 0, no hc_en.
//    start while busy -> ignored.
//  6 Assert rst_n low during ABSORB w=20 -> all outputs 0 async.
//    A fresh test-2 run afterwards yields the correct digest.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, FSM encoding and the SHA-3 padding helper for the hash_core driver.
package sha3_pkg;

  localparam int unsigned STATE_WORDS = 50;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WIDX_W      = 6;
  localparam logic [7:0]  PAD_DS      = 8'h06;
  localparam logic [7:0]  PAD_END     = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EN      = 3'd1,
    ST_GAP     = 3'd2,
    ST_ABSORB  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_SQUEEZE = 3'd5
  } state_e;

  // Build state word w: keep message bytes below len, add domain/end padding, zero the capacity.
  function automatic logic [WORD_W-1:0] pad_word(
    input logic [WORD_W-1:0] data,
    input logic [WIDX_W-1:0] w,
    input logic [7:0]        len,
    input int unsigned       rate_words
  );
    logic [WORD_W-1:0] word;
    int unsigned       idx;
    word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      idx = 32'(w) * 32'd4 + b;
      if (idx < 32'(len)) begin
        word[8*b +: 8] = data[8*b +: 8];
      end
      if (idx == 32'(len)) begin
        word[8*b +: 8] = word[8*b +: 8] ^ PAD_DS;
      end
      if (idx == rate_words * 32'd4 - 32'd1) begin
        word[8*b +: 8] = word[8*b +: 8] ^ PAD_END;
      end
    end
    if (32'(w) >= rate_words) begin
      word = '0;
    end
    return word;
  endfunction

endpackage

// File: rtl/hash_core_driver.sv
// Host-side initiator for the single-block hash_core: pads one message, loads the 50-word
// state image, waits for the permutation and streams the digest words downstream.
module hash_core_driver
  import sha3_pkg::*;
#(
  parameter int unsigned RATE_WORDS = 34,
  parameter int unsigned OUT_WORDS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  msg_bytes,
  input  logic        msg_valid,
  input  logic [31:0] msg_data,
  output logic        msg_ready,
  output logic        dig_valid,
  output logic [31:0] dig_data,
  output logic        dig_last,
  input  logic        dig_ready,
  output logic        busy,
  output logic        err,
  output logic        hc_en,
  output logic        hc_wen,
  output logic [31:0] hc_din,
  output logic        hc_dout_req,
  input  logic [31:0] hc_dout,
  input  logic        hc_valid,
  input  logic        hc_done
);

  localparam int unsigned MSG_MAX = RATE_WORDS * 4;
  localparam int unsigned OIDX_W  = 6;
  localparam logic [WIDX_W-1:0] LAST_W = WIDX_W'(STATE_WORDS - 1);
  localparam logic [OIDX_W-1:0] LAST_O = OIDX_W'(OUT_WORDS - 1);

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [OIDX_W-1:0]   oidx_q, oidx_d;
  logic                msg_ready_q, msg_ready_d;
  logic                dig_valid_q, dig_valid_d;
  logic                dig_last_q, dig_last_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                hc_en_q, hc_en_d;
  logic                hc_wen_q, hc_wen_d;
  logic [WORD_W-1:0]   hc_din_q, hc_din_d;

  logic [6:0]          n_words;
  logic                need_data;
  logic                dig_accept;
  logic                unused_hc_valid;

  // Number of state words that carry upstream message bytes: ceil(len/4).
  assign n_words    = 7'((9'(len_q) + 9'd3) >> 2);
  assign need_data  = ({1'b0, widx_q} < n_words);
  assign dig_accept = dig_valid_q & dig_ready;

  // hash_core valid is observational only; control follows done.
  assign unused_hc_valid = hc_valid;

  assign msg_ready   = msg_ready_q;
  assign dig_valid   = dig_valid_q;
  assign dig_last    = dig_last_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign hc_en       = hc_en_q;
  assign hc_wen      = hc_wen_q;
  assign hc_din      = hc_din_q;
  // Digest path is a pass-through of the core output, gated so it reads zero when idle.
  assign dig_data    = dig_valid_q ? hc_dout : '0;
  // The core advances its read pointer only on a downstream accept.
  assign hc_dout_req = dig_accept;

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    oidx_d   = oidx_q;
    hc_wen_d = 1'b0;
    hc_din_d = '0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ({1'b0, msg_bytes} < 9'(MSG_MAX)) begin
            len_d   = msg_bytes;
            state_d = ST_EN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EN: begin
        widx_d  = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (!need_data || (msg_valid && msg_ready_q)) begin
          hc_wen_d = 1'b1;
          hc_din_d = pad_word(need_data ? msg_data : '0, widx_q, len_q, RATE_WORDS);
          widx_d   = widx_q + WIDX_W'(1);
          if (widx_q == LAST_W) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (hc_done) begin
          oidx_d  = '0;
          state_d = ST_SQUEEZE;
        end
      end
      ST_SQUEEZE: begin
        if (dig_accept) begin
          oidx_d = oidx_q + OIDX_W'(1);
          if (oidx_q == LAST_O) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    msg_ready_d = (state_d == ST_ABSORB) && ({1'b0, widx_d} < n_words);
    dig_valid_d = (state_d == ST_SQUEEZE);
    dig_last_d  = (state_d == ST_SQUEEZE) && (oidx_d == LAST_O);
    busy_d      = (state_d != ST_IDLE);
    hc_en_d     = (state_d == ST_EN);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      widx_q      <= '0;
      oidx_q      <= '0;
      msg_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      hc_en_q     <= 1'b0;
      hc_wen_q    <= 1'b0;
      hc_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      oidx_q      <= oidx_d;
      msg_ready_q <= msg_ready_d;
      dig_valid_q <= dig_valid_d;
      dig_last_q  <= dig_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      hc_en_q     <= hc_en_d;
      hc_wen_q    <= hc_wen_d;
      hc_din_q    <= hc_din_d;
    end
  end

endmodule
